// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column strobe, 2-flop row synchroniser, press and release
// debounce, one valid/ready key event per press. Define KEYPAD_AUTOREPEAT_EN for autorepeat while held.
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 1000,
  localparam int CW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] fila,
  output logic [COLS-1:0] columna,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DWW = $clog2(SCAN_CYCLES);
  localparam int CNW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CLW-1:0] COL_LAST     = CLW'(COLS - 1);
  localparam logic [DWW-1:0] DWELL_LAST   = DWW'(SCAN_CYCLES - 1);
  localparam logic [CNW-1:0] CNT_FULL     = CNW'(DEBOUNCE_CYCLES);
  localparam logic [CNW-1:0] CNT_REL_LAST = CNW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  COLS_K       = CW'(COLS);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [ROWS-1:0] fila_m;
  logic [ROWS-1:0] fila_s;
  logic [1:0]      state;
  logic [CLW-1:0]  col_idx;
  logic [CLW-1:0]  col_next;
  logic [DWW-1:0]  dwell;
  logic [RW-1:0]   row_idx;
  logic [RW-1:0]   row_first;
  logic [CNW-1:0]  cnt;
  logic [CW-1:0]   code_calc;
  logic            row_hit;
  logic            handshake;

  // NOTE: every register below is updated with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fila_m <= '0;
      fila_s <= '0;
    end else begin
      fila_m <= fila;
      fila_s <= fila_m;
    end
  end

  // NOTE: row_first gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    row_first = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (fila_s[r]) row_first = RW'(r);
    end
  end

  assign row_hit   = fila_s[row_idx];
  assign col_next  = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
  assign code_calc = CW'(row_idx) * COLS_K + CW'(col_idx);
  assign handshake = key_valid && key_ready;
  assign columna   = COLS'(1) << col_idx;
  assign key_held  = (state == S_HELD) || (state == S_RELEASE);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_CYCLES - 1);

  logic [RPW-1:0] rep_cnt;
  logic           rep_wrap;

  assign rep_wrap = (rep_cnt == REP_LAST);

  // Runs only while the key stays down in HELD; any other cycle parks it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (state == S_HELD && row_hit) begin
      rep_cnt <= rep_wrap ? '0 : rep_cnt + 1'b1;
    end else begin
      rep_cnt <= '0;
    end
  end
`else
  // The repeat period has no function here; an illegal value still leaves a visible marker scope.
  if (REPEAT_CYCLES < 1) begin : g_illegal_repeat_cycles
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_SCAN;
      col_idx   <= '0;
      dwell     <= '0;
      row_idx   <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      if (handshake) key_valid <= 1'b0;
      case (state)
        S_SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (|fila_s) begin
              row_idx <= row_first;
              cnt     <= '0;
              state   <= S_DEBOUNCE;
            end else begin
              col_idx <= col_next;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        S_DEBOUNCE: begin
          // A completed debounce waits here, saturated, until the previous event is taken.
          if (cnt == CNT_FULL) begin
            if (!key_valid) begin
              key_code  <= code_calc;
              key_valid <= 1'b1;
              state     <= S_HELD;
            end else if (!row_hit) begin
              col_idx <= col_next;
              state   <= S_SCAN;
            end
          end else if (row_hit) begin
            cnt <= cnt + 1'b1;
          end else begin
            col_idx <= col_next;
            state   <= S_SCAN;
          end
        end
        S_HELD: begin
          if (!row_hit) begin
            cnt   <= '0;
            state <= S_RELEASE;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_wrap && !key_valid) begin
            key_valid <= 1'b1;
          end
`endif
        end
        S_RELEASE: begin
          if (row_hit) begin
            state <= S_HELD;
          end else if (cnt == CNT_REL_LAST) begin
            col_idx <= col_next;
            state   <= S_SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed test-plan steps plus randomized key activity,
// every cycle compared against a behavioural keypad model.
module tb_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SCAN = 4;
  localparam int DEB  = 8;
  localparam int REP  = 20;
  localparam int CW   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ROWS-1:0]   fila = '0;
  logic [COLS-1:0]   columna;
  logic [CW-1:0]     key_code;
  logic              key_valid;
  logic              key_ready = 1'b1;
  logic              key_held;
  logic [ROWS*COLS-1:0] keys = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int got_q[$];

  // Behavioural model: scan position, candidate key, confirmed-down flag, release flag.
  int              m_col, m_dwell, m_row, m_cnt, m_rep, m_code;
  bit              m_locked, m_down, m_rel, m_valid;
  logic [ROWS-1:0] m_s1, m_s2;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(SCAN),
    .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .fila(fila), .columna(columna),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [ROWS-1:0] rows_seen();
    logic [ROWS-1:0] f = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (columna[c] === 1'b1 && keys[r*COLS+c]) f[r] = 1'b1;
    return f;
  endfunction

  function automatic int lowest_row(logic [ROWS-1:0] v);
    for (int r = 0; r < ROWS; r++) if (v[r]) return r;
    return 0;
  endfunction

  task automatic model_reset();
    m_col = 0; m_dwell = 0; m_row = 0; m_cnt = 0; m_rep = 0; m_code = 0;
    m_locked = 0; m_down = 0; m_rel = 0; m_valid = 0;
    m_s1 = '0; m_s2 = '0;
  endtask

  task automatic next_column();
    m_locked = 0;
    m_dwell  = 0;
    m_col    = (m_col + 1) % COLS;
  endtask

  task automatic model_update();
    logic [ROWS-1:0] fs;
    bit on, was_valid;
    if (rst) begin
      model_reset();
      return;
    end
    fs = m_s2;
    on = fs[m_row];
    was_valid = m_valid;
    if (m_valid && key_ready) m_valid = 0;
    if (!m_locked) begin
      if (m_dwell == SCAN - 1) begin
        m_dwell = 0;
        if (fs != 0) begin
          m_row = lowest_row(fs); m_locked = 1; m_cnt = 0;
        end else begin
          m_col = (m_col + 1) % COLS;
        end
      end else begin
        m_dwell++;
      end
    end else if (!m_down) begin
      if (m_cnt == DEB) begin
        if (!was_valid) begin
          m_code = m_row * COLS + m_col; m_valid = 1; m_down = 1; m_rel = 0; m_rep = 0;
        end else if (!on) begin
          next_column();
        end
      end else if (on) begin
        m_cnt++;
      end else begin
        next_column();
      end
    end else if (!m_rel) begin
      if (!on) begin
        m_rel = 1; m_cnt = 0; m_rep = 0;
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      else if (m_rep == REP - 1) begin
        m_rep = 0;
        if (!was_valid) m_valid = 1;
      end else begin
        m_rep++;
      end
`endif
    end else begin
      if (on) begin
        m_rel = 0; m_rep = 0;
      end else begin
        m_cnt++;
        if (m_cnt == DEB) begin
          m_down = 0; m_rel = 0;
          next_column();
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = fila;
  endtask

  task automatic compare_model();
    check("columna",   32'(columna),   32'(1 << m_col));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_code",  32'(key_code),  32'(m_code));
    check("key_held",  32'(key_held),  32'(m_down));
  endtask

  task automatic step();
    if (key_valid === 1'b1 && key_ready) got_q.push_back(int'(key_code));
    fila = rows_seen();
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    compare_model();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic wait_valid(string tag);
    int w = 0;
    while (key_valid !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    check(tag, 32'(w < 100), 32'd1);
  endtask

  initial begin
    model_reset();

    // Reset held for two edges
    run(2);
    check("rst_columna", 32'(columna), 32'b0001);
    check("rst_valid",   32'(key_valid), 32'd0);
    check("rst_held",    32'(key_held), 32'd0);
    check("rst_code",    32'(key_code), 32'd0);
    rst = 1'b0;

    // Idle scan: column advances every SCAN cycles
    for (int i = 0; i < 32; i++) begin
      step();
      if ((i + 1) % SCAN == 0)
        check("idle_col", 32'(columna), 32'(1 << (((i + 1) / SCAN) % COLS)));
    end

    // Clean press of key 6 (row 1, column 2)
    got_q.delete();
    keys[6] = 1'b1;
    run(60);
    check("clean_held", 32'(key_held), 32'd1);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("clean_events", 32'(got_q.size()), 32'd1);
    check("clean_code", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hffff_ffff, 32'd6);
`endif
    keys = '0;
    run(12);
    check("clean_release_held", 32'(key_held), 32'd0);
    check("clean_resume_col",   32'(columna), 32'b1000);

    // Press bounce then stable press on key 0
    got_q.delete();
    begin
      int pat[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
      int wid[8] = '{2, 1, 3, 2, 1, 3, 2, 1};
      for (int p = 0; p < 8; p++) begin
        keys[0] = pat[p][0];
        run(wid[p]);
      end
    end
    keys[0] = 1'b1;
    run(40);
    check("bounce_held", 32'(key_held), 32'd1);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("bounce_events", 32'(got_q.size()), 32'd1);
    check("bounce_code", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hffff_ffff, 32'd0);
`endif
    // Release bounce with 2-cycle pulses
    for (int p = 0; p < 3; p++) begin
      keys[0] = 1'b0; run(2);
      keys[0] = 1'b1; run(2);
    end
    check("rel_bounce_held", 32'(key_held), 32'd1);
    keys[0] = 1'b0;
    run(12);
    check("rel_bounce_done", 32'(key_held), 32'd0);

    // Backpressure: key 5 pending while key 10 waits
    key_ready = 1'b0;
    keys[5] = 1'b1;  run(40);
    keys[5] = 1'b0;  run(14);
    keys[10] = 1'b1; run(40);
    check("bp_valid_5", 32'(key_valid), 32'd1);
    check("bp_code_5",  32'(key_code),  32'd5);
    key_ready = 1'b1; run(1);
    check("bp_valid_drop", 32'(key_valid), 32'd0);
    key_ready = 1'b0; run(1);
    check("bp_valid_10", 32'(key_valid), 32'd1);
    check("bp_code_10",  32'(key_code),  32'd10);
    check("bp_held_10",  32'(key_held),  32'd1);

    // Asynchronous reset between edges while held with an event pending
    #3 rst = 1'b1;
    #1;
    check("arst_columna", 32'(columna), 32'b0001);
    check("arst_valid",   32'(key_valid), 32'd0);
    check("arst_held",    32'(key_held), 32'd0);
    check("arst_code",    32'(key_code), 32'd0);
    model_reset();
    step();
    rst = 1'b0;
    key_ready = 1'b1;
    got_q.delete();
    run(3);
    check("arst_no_early_event", 32'(key_valid), 32'd0);
    run(37);
`ifndef KEYPAD_AUTOREPEAT_EN
    check("arst_new_events", 32'(got_q.size()), 32'd1);
    check("arst_new_code", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hffff_ffff, 32'd10);
`endif
    keys = '0;
    run(20);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Autorepeat on key 3 with the consumer ready, then with it stalled
    got_q.delete();
    keys[3] = 1'b1;
    wait_valid("ar_detect");
    run(70);
    check("ar_events", 32'(got_q.size()), 32'd4);
    keys = '0; run(15);
    key_ready = 1'b0;
    got_q.delete();
    keys[3] = 1'b1;
    wait_valid("ar_bp_detect");
    run(70);
    keys = '0; run(15);
    key_ready = 1'b1; run(3);
    check("ar_bp_events", 32'(got_q.size()), 32'd1);
`endif

    // Randomized presses with chatter, occasional second key, random backpressure
    for (int t = 0; t < 40; t++) begin
      logic [ROWS*COLS-1:0] base;
      int len;
      base = '0;
      base[$urandom_range(0, ROWS*COLS-1)] = 1'b1;
      if ($urandom_range(0, 3) == 0) base[$urandom_range(0, ROWS*COLS-1)] = 1'b1;
      len = $urandom_range(5, 45);
      for (int i = 0; i < len; i++) begin
        key_ready = ($urandom_range(0, 9) < 7);
        keys = (i < 6 && $urandom_range(0, 2) == 0) ? '0 : base;
        step();
      end
      keys = '0;
      run($urandom_range(0, 20));
    end
    key_ready = 1'b1;
    run(30);
    check("final_idle_valid", 32'(key_valid), 32'd0);
    check("final_idle_held",  32'(key_held),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix keypad scanner with per-key debounce and a valid/ready key-event output. It drives one-hot column strobes, samples the row lines through a 2-flop synchroniser, and debounces both press and release. Each debounced press produces one key code for the downstream operand-capture / ALU control logic. It is the generalised successor to the fixed 4-row, row-only debouncer, with configurable matrix size, dwell and debounce lengths.

## Interface
- ROWS, 4, number of row inputs (≥1)
- COLS, 4, number of column strobes (≥1)
- SCAN_CYCLES, 4, clock cycles each column is driven before sampling (≥3)
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required for press and for release (≥1)
- REPEAT_CYCLES, 1000, autorepeat period; used only when KEYPAD_AUTOREPEAT_EN is defined
- CW, $clog2(ROWS*COLS) (min 1), key code width (localparam)

Ports:
- clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- fila  in  ROWS  raw row lines, active-high (1 = key closed on strobed column), asynchronous
- columna  out  COLS  one-hot column strobe, active-high
- key_code  out  CW  row*COLS + col of the last debounced press
- key_valid  out  1  event pending
- key_ready  in  1  consumer accepts event when key_valid && key_ready
- key_held  out  1  high while a debounced key is held

## Operation
- fila passes through a 2-flop synchroniser (fila_s); all decisions use fila_s only.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN: columna = 1<<col_idx; dwell counter counts 0..SCAN_CYCLES-1. On the last dwell cycle:
  - if fila_s != 0: latch row_idx = lowest set bit, clear debounce counter, go DEBOUNCE (column held).
  - else: col_idx wraps COLS-1 → 0, otherwise increments; dwell restarts.
- DEBOUNCE: each cycle fila_s[row_idx]=1 increments the counter (saturating at DEBOUNCE_CYCLES); fila_s[row_idx]=0 returns to SCAN with col_idx advanced.
  - Counter == DEBOUNCE_CYCLES and key_valid=0: load key_code, set key_valid, go HELD.
  - Counter == DEBOUNCE_CYCLES and key_valid=1: wait in DEBOUNCE (counter saturated) until key_valid drops; a release while waiting returns to SCAN and the event is lost.
- HELD: key_held=1. fila_s[row_idx]=0 clears the counter and goes RELEASE.
- RELEASE: key_held=1. Counts consecutive fila_s[row_idx]=0 cycles; any 1 returns to HELD (bounce). At DEBOUNCE_CYCLES: key_held=0, col_idx advances, go SCAN.
- Handshake: key_valid clears on the edge where key_valid && key_ready. key_code is stable while key_valid=1. Only one event is outstanding at a time. A set and a clear on the same edge cannot occur: setting requires key_valid=0.
- Multiple rows high on one column: lowest row index wins. Other columns are not examined until release completes.

## Timing
- Reset (async, immediate): state SCAN, col_idx 0, columna = 1, key_code 0, key_valid 0, key_held 0, counters and synchroniser 0.
- Synchroniser latency: 2 cycles from fila to fila_s.
- Press latency: key_valid rises on the edge after the DEBOUNCE_CYCLES-th consecutive high fila_s sample in DEBOUNCE.
  - Worst case from stable press: 2 + COLS*SCAN_CYCLES + DEBOUNCE_CYCLES + 1 cycles.
- Release: key_held falls DEBOUNCE_CYCLES cycles after fila_s goes stably low.
- Reset mid-event discards any pending or in-progress event.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - In HELD, a repeat counter counts to REPEAT_CYCLES and restarts.
  - At wrap, if key_valid=0, key_valid is reasserted with the same key_code. If key_valid=1, that repeat is skipped.
  - The counter clears on entry to HELD and does not run in RELEASE.
- Undefined: exactly one event per debounced press; the repeat counter is not synthesised.

## Test plan
Parameters: ROWS=4, COLS=4, SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, key_ready=1 unless stated.
- Reset: rst=1 for 2 cycles → columna=0001, key_valid=0, key_held=0, key_code=0. Idle fila=0 for 32 cycles → columna cycles 0001→0010→0100→1000→0001 every 4 cycles.
- Clean press: fila[1]=1 only while columna=0100, held 60 cycles → exactly one key_valid pulse with key_code=6, key_held=1. After release plus 8 cycles → key_held=0, scanning resumes at columna=1000.
- Bounce: on column 0, fila[0] toggles 1/0/1/0 with 1–3-cycle widths, then stable 1 for 20 cycles → exactly one event, key_code=0. Release bounce of 2-cycle pulses → key_held remains 1 until 8 stable low cycles.
- Backpressure: key_ready=0; press key 5, release, press key 10 → key_valid stays high with key_code=5. Raise key_ready for 1 cycle while key 10 still held → key_valid drops, then rises next cycle with key_code=10.
- Async reset mid-HELD: assert rst between clock edges while key_held=1 and key_valid=1 → all outputs return to reset values before the next edge. No event follows until a new full debounce.
- KEYPAD_AUTOREPEAT_EN, REPEAT_CYCLES=20: hold key 3 for 70 cycles after detection → 1 + 3 events with key_code=3. With key_ready=0 throughout → only 1 event is ever pending.
